// File: rtl/a2d_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : a2d_sequencer_if
// Brief    : Request / SPI handshake / result bundle for the A2D sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface a2d_sequencer_if;
   logic        nxt;
   logic        done;
   logic [15:0] rd_data;
   logic        wrt;
   logic [15:0] cmd;
   logic [11:0] lft_ld;
   logic [11:0] rght_ld;
   logic [11:0] steer_pot;
   logic [11:0] batt;
   logic        rnd_done;
   logic        tmo;

   modport master (
      input  nxt, done, rd_data,
      output wrt, cmd, lft_ld, rght_ld, steer_pot, batt, rnd_done, tmo
   );

   modport slave (
      output nxt, done, rd_data,
      input  wrt, cmd, lft_ld, rght_ld, steer_pot, batt, rnd_done, tmo
   );
endinterface
`default_nettype wire

// File: rtl/a2d_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : a2d_sequencer
// Brief    : Round-robin A2D sampler (lft, rght, steer_pot, batt) over SPI.
// Revision : 1.0  initial release
// ============================================================================
module a2d_sequencer #(
   parameter bit FAST_SIM = 1'b0
) (
   input  wire logic        clk,
   input  wire logic        rst,
   a2d_sequencer_if.master  bus
);
   localparam logic [1:0]  c_IDLE = 2'd0;
   localparam logic [1:0]  c_CNV  = 2'd1;
   localparam logic [1:0]  c_GAP  = 2'd2;
   localparam logic [1:0]  c_READ = 2'd3;
   localparam logic [15:0] c_WDOG_LAST = FAST_SIM ? 16'd511 : 16'd65535;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [1:0]  r_ptr;
   logic [15:0] r_wdog;
   logic        r_wrt;
   logic [15:0] r_cmd;
   logic [11:0] r_lft_ld, r_rght_ld, r_steer_pot, r_batt;
   logic        r_rnd_done;
   logic        r_tmo;

   logic        w_busy;
   logic        w_expire;
   logic        w_start;
   logic        w_rd_wr;
   logic        w_wrt_nxt;
   logic [15:0] w_cmd_nxt;
   logic [2:0]  w_chnl;
   logic        w_unused_rd;

   assign w_unused_rd = ^bus.rd_data[15:12];
   assign w_busy   = (r_state == c_CNV) || (r_state == c_READ);
   // A done arriving on the expiry edge wins over the watchdog.
   assign w_expire = w_busy && !bus.done && (r_wdog == c_WDOG_LAST);

   always_ff @(posedge clk) begin
      if (rst) r_state <= c_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: if (bus.nxt) w_state_nxt = c_CNV;
         c_CNV: begin
            if (bus.done)     w_state_nxt = c_GAP;
            else if (w_expire) w_state_nxt = c_IDLE;
         end
         c_GAP:  w_state_nxt = c_READ;
         c_READ: if (bus.done || w_expire) w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      w_start   = (r_state == c_IDLE) && bus.nxt;
      w_rd_wr   = (r_state == c_READ) && bus.done;
      w_wrt_nxt = w_start || (r_state == c_GAP);
      case (r_ptr)
         2'd0:    w_chnl = 3'd0;
         2'd1:    w_chnl = 3'd4;
         2'd2:    w_chnl = 3'd5;
         default: w_chnl = 3'd6;
      endcase
      w_cmd_nxt = r_cmd;
      if (w_start)                   w_cmd_nxt = {2'b00, w_chnl, 11'h000};
      else if (r_state == c_GAP)     w_cmd_nxt = 16'h0000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= 2'd0;
         r_wdog      <= 16'd0;
         r_wrt       <= 1'b0;
         r_cmd       <= 16'h0000;
         r_lft_ld    <= 12'h000;
         r_rght_ld   <= 12'h000;
         r_steer_pot <= 12'h000;
         r_batt      <= 12'h000;
         r_rnd_done  <= 1'b0;
         r_tmo       <= 1'b0;
      end else begin
         r_wrt      <= w_wrt_nxt;
         r_cmd      <= w_cmd_nxt;
         r_rnd_done <= w_rd_wr && (r_ptr == 2'd3);
         if (w_wrt_nxt || !w_busy) r_wdog <= 16'd0;
         else                      r_wdog <= r_wdog + 16'd1;
         if (w_expire) r_tmo <= 1'b1;
         if (w_rd_wr) begin
            r_ptr <= r_ptr + 2'd1;
            case (r_ptr)
               2'd0:    r_lft_ld    <= bus.rd_data[11:0];
               2'd1:    r_rght_ld   <= bus.rd_data[11:0];
               2'd2:    r_steer_pot <= bus.rd_data[11:0];
               default: r_batt      <= bus.rd_data[11:0];
            endcase
         end
      end
   end

   assign bus.wrt       = r_wrt;
   assign bus.cmd       = r_cmd;
   assign bus.lft_ld    = r_lft_ld;
   assign bus.rght_ld   = r_rght_ld;
   assign bus.steer_pot = r_steer_pot;
   assign bus.batt      = r_batt;
   assign bus.rnd_done  = r_rnd_done;
   assign bus.tmo       = r_tmo;
endmodule
`default_nettype wire
